dct_1d_nx1_seq: RTL



---
 rtl/dct_1d_nx1_seq_if.sv | 27 ++
 rtl/dct_1d_nx1_seq.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dct_1d_nx1_seq_if.sv
// Handshake and data bundle for the sequential N-point 1-D DCT engine.
// master: the side that supplies vectors and consumes results.
// slave : the DCT engine itself.
interface dct_1d_nx1_seq_if #(
  parameter int N           = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 17
);
  logic                            in_valid;
  logic                            in_ready;
  logic                            in_mode;
  logic [N*DATA_WIDTH-1:0]         in_data;
  logic [N*N*COEFF_WIDTH-1:0]      coeff_matrix;
  logic                            out_valid;
  logic                            out_ready;
  logic [N*DATA_WIDTH-1:0]         out_data;

  modport master (
    output in_valid, in_mode, in_data, coeff_matrix, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_data, coeff_matrix, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dct_1d_nx1_seq.sv
// Sequential N-point 1-D DCT/IDCT engine: N parallel MAC lanes, one input
// sample per cycle, rounded and scaled by 2^-FRAC_BITS on the way out.
// Optional build macro DCT_SEQ_SAT_EN: saturate results to the signed
// DATA_WIDTH range instead of two's-complement wrapping.
module dct_1d_nx1_seq #(
  parameter int N           = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 17,
  parameter int FRAC_BITS   = 14
) (
  input logic               clk,
  input logic               reset,
  dct_1d_nx1_seq_if.slave   bus
);

  localparam int ACC_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(N);
  localparam int JW        = $clog2(N);
  localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH+1)'(1) << (FRAC_BITS-1);
`ifdef DCT_SEQ_SAT_EN
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;

  state_t                       state_q, state_d;
  logic                         armed_q;
  logic                         accept;
  logic                         mode_q;
  logic [JW-1:0]                j_q;
  logic signed [DATA_WIDTH-1:0] x_q   [N];
  logic signed [COEFF_WIDTH-1:0] c_q  [N][N];
  logic signed [ACC_WIDTH-1:0]  acc_q [N];
  logic signed [ACC_WIDTH-1:0]  acc_d [N];
  logic signed [ACC_WIDTH-1:0]  x_ext;
  logic signed [ACC_WIDTH-1:0]  c_ext [N];
  logic signed [ACC_WIDTH:0]    rnd   [N];
  logic [N*DATA_WIDTH-1:0]      out_q, out_d;

  assign bus.out_data = out_q;

  // State register; armed_q holds in_ready low for the first cycle after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = armed_q;
        if (armed_q && bus.in_valid) begin
          accept  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: if (j_q == JW'(N-1)) state_d = SCALE;
      SCALE: state_d = OUT;
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // MAC lanes: lane i adds x[j]*C[i][j] (forward) or x[j]*C[j][i] (inverse)
  always_comb begin
    x_ext = ACC_WIDTH'(x_q[j_q]);
    for (int unsigned i = 0; i < N; i++) begin
      c_ext[i] = mode_q ? ACC_WIDTH'(c_q[j_q][i]) : ACC_WIDTH'(c_q[i][j_q]);
      acc_d[i] = acc_q[i] + x_ext * c_ext[i];
    end
  end

  // Round half toward +inf, drop FRAC_BITS, narrow to DATA_WIDTH
  always_comb begin
    out_d = out_q;
    for (int unsigned i = 0; i < N; i++) begin
      rnd[i] = {acc_q[i][ACC_WIDTH-1], acc_q[i]} + RND;
`ifdef DCT_SEQ_SAT_EN
      if ((rnd[i] >>> FRAC_BITS) > SAT_MAX)
        out_d[i*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
      else if ((rnd[i] >>> FRAC_BITS) < SAT_MIN)
        out_d[i*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
      else
        out_d[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(rnd[i] >>> FRAC_BITS);
`else
      out_d[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(rnd[i] >>> FRAC_BITS);
`endif
    end
  end

  // Operand capture, accumulation and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 1'b0;
      j_q    <= '0;
      out_q  <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        x_q[i]   <= '0;
        acc_q[i] <= '0;
        for (int unsigned k = 0; k < N; k++) c_q[i][k] <= '0;
      end
    end else if (accept) begin
      mode_q <= bus.in_mode;
      j_q    <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        x_q[i]   <= bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        acc_q[i] <= '0;
        for (int unsigned k = 0; k < N; k++)
          c_q[i][k] <= bus.coeff_matrix[(i*N+k)*COEFF_WIDTH +: COEFF_WIDTH];
      end
    end else if (state_q == ACCUM) begin
      j_q <= j_q + JW'(1);
      for (int unsigned i = 0; i < N; i++) acc_q[i] <= acc_d[i];
    end else if (state_q == SCALE) begin
      out_q <= out_d;
    end
  end

endmodule
